// File: rtl/job_scheduler_rr.sv
// job_scheduler_rr
//   Takes job descriptors from the descriptor manager and starts each one on a
//   free, enabled kernel. Kernels are chosen round-robin. The block keeps the
//   {pid, jobid} of the job running on each kernel. It sends one completion
//   record per finished job to the completion manager. If several kernels
//   finish together, their completions wait as per-kernel pending bits and are
//   sent one per cycle, also round-robin.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   dsc0_ready_i      a descriptor is available
//   dsc0_pull_o       consume the descriptor this cycle (combinational)
//   dsc0_data_i       descriptor; jobid = [63:32], pid = [PID_W-1:0]
//   kernel_enable_i   per kernel: 1 = may receive new jobs
//   engine_start      one-hot start pulse to the granted kernel (registered)
//   jd_payload        descriptor for the started kernel (registered)
//   engine_done       per-kernel done level; a rising edge ends the job
//   complete_ready_i  the completion sink can accept a record
//   complete_push_o   completion record valid, one-cycle pulse (registered)
//   return_data_o     {pid, jobid} of the completed job; 0 when no push
//   busy_cnt_o        number of kernels that are busy or have a pending completion
module job_scheduler_rr #(
    parameter int KERNEL_NUM = 8,
    parameter int DSC_W      = 1024,
    parameter int PID_W      = 9,
    parameter int JOBID_W    = 32
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               dsc0_ready_i,
    output logic                               dsc0_pull_o,
    input  logic [DSC_W-1:0]                   dsc0_data_i,
    input  logic [KERNEL_NUM-1:0]              kernel_enable_i,
    output logic [KERNEL_NUM-1:0]              engine_start,
    output logic [DSC_W-1:0]                   jd_payload,
    input  logic [KERNEL_NUM-1:0]              engine_done,
    input  logic                               complete_ready_i,
    output logic                               complete_push_o,
    output logic [PID_W+JOBID_W-1:0]           return_data_o,
    output logic [$clog2(KERNEL_NUM+1)-1:0]    busy_cnt_o
);

    localparam int PTR_W  = (KERNEL_NUM > 1) ? $clog2(KERNEL_NUM) : 1;
    localparam int CNT_W  = $clog2(KERNEL_NUM + 1);
    localparam int INFO_W = PID_W + JOBID_W;

    // The jobid field sits at [63:32], so narrower descriptors cannot carry it.
    generate
        if (DSC_W < 64 || PID_W > 32 || PID_W < 1 || JOBID_W != 32 ||
            KERNEL_NUM < 1 || KERNEL_NUM > 64) begin : g_bad_params
            $error("job_scheduler_rr: illegal parameters (need DSC_W>=64, PID_W<=32, JOBID_W==32, 1<=KERNEL_NUM<=64)");
        end
    endgenerate

    // First requester at or above ptr, wrapping at KERNEL_NUM-1.
    function automatic logic [PTR_W-1:0] rr_pick(input logic [KERNEL_NUM-1:0] req,
                                                  input logic [PTR_W-1:0]      ptr);
        logic [PTR_W-1:0]      g;
        logic                  found;
        logic [KERNEL_NUM-1:0] sh;
        int                    idx;
        g     = '0;
        found = 1'b0;
        for (int i = 0; i < KERNEL_NUM; i++) begin
            idx = int'(ptr) + i;
            if (idx >= KERNEL_NUM) idx = idx - KERNEL_NUM;
            sh = req >> idx;
            if (!found && sh[0]) begin
                found = 1'b1;
                g     = PTR_W'(idx);
            end
        end
        return g;
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] g);
        return (int'(g) == KERNEL_NUM - 1) ? '0 : g + PTR_W'(1);
    endfunction

    logic [KERNEL_NUM-1:0] r_busy;
    logic [KERNEL_NUM-1:0] r_pending;
    logic [KERNEL_NUM-1:0] r_done_prev;
    logic [PTR_W-1:0]      r_disp_ptr;
    logic [PTR_W-1:0]      r_cpl_ptr;
    logic [INFO_W-1:0]     r_info [KERNEL_NUM];

    logic [KERNEL_NUM-1:0] w_free;
    logic                  w_pull;
    logic [PTR_W-1:0]      w_disp_gnt;
    logic [KERNEL_NUM-1:0] w_start_oh;
    logic [KERNEL_NUM-1:0] w_done_rise;
    logic [KERNEL_NUM-1:0] w_fin;
    logic                  w_cpl_fire;
    logic [PTR_W-1:0]      w_cpl_gnt;
    logic [KERNEL_NUM-1:0] w_cpl_oh;
    logic [KERNEL_NUM-1:0] w_busy_nxt;
    logic [KERNEL_NUM-1:0] w_pend_nxt;
    logic [CNT_W-1:0]      w_cnt_nxt;

    // A kernel stays unavailable until its completion record has been pushed.
    assign w_free     = kernel_enable_i & ~r_busy & ~r_pending;
    // Blocking on engine_start limits pulls to one every two cycles, so the
    // busy bit set by the previous grant is visible before the next one.
    assign w_pull     = dsc0_ready_i & (|w_free) & ~(|engine_start) & ~rst;
    assign w_disp_gnt = rr_pick(w_free, r_disp_ptr);
    assign w_start_oh = w_pull ? (KERNEL_NUM'(1) << w_disp_gnt) : '0;

    // done_prev resets to all ones, so a done level already high out of reset
    // is not taken as a completion. A rise on an idle kernel is ignored.
    assign w_done_rise = engine_done & ~r_done_prev;
    assign w_fin       = w_done_rise & r_busy;

    assign w_cpl_fire = complete_ready_i & (|r_pending);
    assign w_cpl_gnt  = rr_pick(r_pending, r_cpl_ptr);
    assign w_cpl_oh   = w_cpl_fire ? (KERNEL_NUM'(1) << w_cpl_gnt) : '0;

    // Set and clear never hit the same kernel: a pending kernel is not busy,
    // and a busy kernel is never granted.
    assign w_busy_nxt = (r_busy & ~w_fin) | w_start_oh;
    assign w_pend_nxt = (r_pending | w_fin) & ~w_cpl_oh;

    always_comb begin
        w_cnt_nxt = '0;
        for (int i = 0; i < KERNEL_NUM; i++)
            w_cnt_nxt = w_cnt_nxt + CNT_W'(w_busy_nxt[i] | w_pend_nxt[i]);
    end

    assign dsc0_pull_o = w_pull;

    always_ff @(posedge clk) begin
        if (rst) begin
            engine_start    <= '0;
            jd_payload      <= '0;
            complete_push_o <= 1'b0;
            return_data_o   <= '0;
            busy_cnt_o      <= '0;
            r_busy          <= '0;
            r_pending       <= '0;
            r_done_prev     <= '1;
            r_disp_ptr      <= '0;
            r_cpl_ptr       <= '0;
        end else begin
            engine_start    <= w_start_oh;
            r_busy          <= w_busy_nxt;
            r_pending       <= w_pend_nxt;
            r_done_prev     <= engine_done;
            busy_cnt_o      <= w_cnt_nxt;
            complete_push_o <= w_cpl_fire;
            return_data_o   <= w_cpl_fire ? r_info[w_cpl_gnt] : '0;
            if (w_pull) begin
                jd_payload <= dsc0_data_i;
                r_disp_ptr <= ptr_inc(w_disp_gnt);
            end
            if (w_cpl_fire)
                r_cpl_ptr <= ptr_inc(w_cpl_gnt);
        end
    end

    // Info is only read back for kernels whose busy bit was set by a grant,
    // so it needs no reset.
    always_ff @(posedge clk) begin
        if (w_pull)
            r_info[w_disp_gnt] <= {dsc0_data_i[PID_W-1:0], dsc0_data_i[63:32]};
    end

endmodule

// File: tb/tb_job_scheduler_rr.sv
// Directed bench for job_scheduler_rr (KERNEL_NUM=8, DSC_W=1024, PID_W=9).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_job_scheduler_rr;

    localparam int K     = 8;
    localparam int DSC_W = 1024;
    localparam int PID_W = 9;

    logic               clk = 1'b0;
    logic               rst;
    logic               dsc_ready;
    logic               pull;
    logic [DSC_W-1:0]   dsc_data;
    logic [K-1:0]       enable;
    logic [K-1:0]       start;
    logic [DSC_W-1:0]   payload;
    logic [K-1:0]       done;
    logic               cpl_ready;
    logic               push;
    logic [PID_W+31:0]  ret;
    logic [3:0]         busy_cnt;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    job_scheduler_rr #(.KERNEL_NUM(K), .DSC_W(DSC_W), .PID_W(PID_W), .JOBID_W(32)) dut (
        .clk              (clk),
        .rst              (rst),
        .dsc0_ready_i     (dsc_ready),
        .dsc0_pull_o      (pull),
        .dsc0_data_i      (dsc_data),
        .kernel_enable_i  (enable),
        .engine_start     (start),
        .jd_payload       (payload),
        .engine_done      (done),
        .complete_ready_i (cpl_ready),
        .complete_push_o  (push),
        .return_data_o    (ret),
        .busy_cnt_o       (busy_cnt)
    );

    task automatic chk(input string tag, input logic [1023:0] act, input logic [1023:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [DSC_W-1:0] mk(input logic [31:0] jobid, input logic [8:0] pid);
        logic [DSC_W-1:0] d;
        d        = '0;
        d[63:32] = jobid;
        d[8:0]   = pid;
        d[DSC_W-1 -: 8] = 8'hA5;  // marks the upper payload bits
        return d;
    endfunction

    task automatic nxt();
        @(negedge clk);
    endtask

    task automatic do_reset();
        nxt();
        rst       = 1'b1;
        dsc_ready = 1'b0;
        done      = '1;
        nxt();
        nxt();
        rst = 1'b0;
    endtask

    // Offers one descriptor at the current falling edge and checks the start
    // one cycle later. Returns on the edge where engine_start is high.
    task automatic dispatch(input logic [31:0] jobid, input logic [8:0] pid,
                            input logic [K-1:0] exp_oh, input string tag);
        dsc_data  = mk(jobid, pid);
        dsc_ready = 1'b1;
        #1;
        chk({tag, "_pull"}, pull, 1'b1);
        nxt();
        dsc_ready = 1'b0;
        chk({tag, "_start"}, start, exp_oh);
        chk({tag, "_payload"}, payload, mk(jobid, pid));
    endtask

    // Falling edge of done on the masked kernels, then rise on the next cycle.
    task automatic pulse_done(input logic [K-1:0] mask);
        done = ~mask;
        nxt();
        done = '1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst       = 1'b1;
        dsc_ready = 1'b0;
        dsc_data  = '0;
        enable    = '1;
        done      = '1;
        cpl_ready = 1'b1;

        // ---- reset state and single job round trip ----
        nxt();
        nxt();
        dsc_ready = 1'b1;
        dsc_data  = mk(32'h11, 9'h005);
        #1;
        chk("rst_pull", pull, 1'b0);
        chk("rst_start", start, '0);
        chk("rst_payload", payload, '0);
        chk("rst_push", push, 1'b0);
        chk("rst_ret", ret, '0);
        chk("rst_busy_cnt", busy_cnt, 4'd0);
        dsc_ready = 1'b0;
        rst       = 1'b0;
        nxt();
        dispatch(32'h11, 9'h005, 8'h01, "t1");
        chk("t1_no_pull_while_start", pull, 1'b0);
        nxt();
        chk("t1_start_one_cycle", start, '0);
        chk("t1_busy_cnt", busy_cnt, 4'd1);
        pulse_done(8'h01);
        nxt();
        chk("t1_push_early", push, 1'b0);
        chk("t1_pending_cnt", busy_cnt, 4'd1);
        nxt();
        chk("t1_push", push, 1'b1);
        chk("t1_ret", ret, {9'h005, 32'h11});
        chk("t1_cnt_after", busy_cnt, 4'd0);
        nxt();
        chk("t1_push_pulse", push, 1'b0);
        chk("t1_ret_zero", ret, '0);

        // ---- fill all kernels, ninth job waits for kernel 3 ----
        do_reset();
        for (int j = 0; j < K; j++) begin
            dispatch(32'h100 + j, 9'(j), 8'(1 << j), $sformatf("t2_k%0d", j));
            nxt();
        end
        dsc_data  = mk(32'h108, 9'h008);
        dsc_ready = 1'b1;
        #1;
        chk("t2_full_pull", pull, 1'b0);
        chk("t2_full_cnt", busy_cnt, 4'd8);
        pulse_done(8'h08);
        nxt();
        nxt();
        chk("t2_k3_push", push, 1'b1);
        chk("t2_k3_ret", ret, {9'h003, 32'h103});
        chk("t2_ninth_pull", pull, 1'b1);
        nxt();
        dsc_ready = 1'b0;
        chk("t2_ninth_start", start, 8'h08);
        chk("t2_ninth_payload", payload, mk(32'h108, 9'h008));

        // ---- round-robin wrap: ptr=6 with 6,7 busy -> kernel 0 ----
        do_reset();
        enable = 8'hC0;
        dispatch(32'h301, 9'h001, 8'h40, "t3_a");
        nxt();
        dispatch(32'h302, 9'h002, 8'h80, "t3_b");
        nxt();
        enable = 8'h20;
        dispatch(32'h303, 9'h003, 8'h20, "t3_c");
        nxt();
        enable = 8'hFF;
        dispatch(32'h304, 9'h004, 8'h01, "t3_wrap");
        nxt();

        // ---- simultaneous completions and back-pressure ----
        do_reset();
        for (int k = 0; k < K; k++) begin
            dispatch(32'h200 + k, 9'(9'h10 + k), 8'(1 << k), $sformatf("t4_k%0d", k));
            nxt();
        end
        pulse_done(8'h52);
        nxt();
        chk("t4_push_early", push, 1'b0);
        nxt();
        chk("t4_push1", push, 1'b1);
        chk("t4_ret1", ret, {9'h011, 32'h201});
        nxt();
        chk("t4_push4", push, 1'b1);
        chk("t4_ret4", ret, {9'h014, 32'h204});
        nxt();
        chk("t4_push6", push, 1'b1);
        chk("t4_ret6", ret, {9'h016, 32'h206});
        nxt();
        chk("t4_push_end", push, 1'b0);
        chk("t4_ret_end", ret, '0);
        cpl_ready = 1'b0;
        pulse_done(8'h05);
        for (int c = 0; c < 5; c++) begin
            nxt();
            chk($sformatf("t4_hold%0d", c), push, 1'b0);
        end
        chk("t4_hold_cnt", busy_cnt, 4'd5);
        cpl_ready = 1'b1;
        nxt();
        chk("t4_late0_push", push, 1'b1);
        chk("t4_late0_ret", ret, {9'h010, 32'h200});
        nxt();
        chk("t4_late2_push", push, 1'b1);
        chk("t4_late2_ret", ret, {9'h012, 32'h202});
        nxt();
        chk("t4_late_end", push, 1'b0);

        // ---- kernel enables ----
        do_reset();
        enable = 8'hFE;
        for (int k = 1; k < K; k++) begin
            dispatch(32'h500 + k, 9'(k), 8'(1 << k), $sformatf("t5_k%0d", k));
            nxt();
        end
        dsc_data  = mk(32'h5FF, 9'h01F);
        dsc_ready = 1'b1;
        #1;
        chk("t5_no_k0", pull, 1'b0);
        enable = 8'hFA;
        pulse_done(8'h04);
        nxt();
        nxt();
        chk("t5_dis_push", push, 1'b1);
        chk("t5_dis_ret", ret, {9'h002, 32'h502});
        chk("t5_dis_no_reissue", pull, 1'b0);
        dsc_ready = 1'b0;

        // ---- reset with jobs outstanding ----
        do_reset();
        enable = 8'hFF;
        for (int k = 0; k < 3; k++) begin
            dispatch(32'h600 + k, 9'(k), 8'(1 << k), $sformatf("t6_k%0d", k));
            nxt();
        end
        chk("t6_pre_cnt", busy_cnt, 4'd3);
        rst = 1'b1;
        nxt();
        chk("t6_start", start, '0);
        chk("t6_payload", payload, '0);
        chk("t6_push", push, 1'b0);
        chk("t6_ret", ret, '0);
        chk("t6_cnt", busy_cnt, 4'd0);
        rst = 1'b0;
        nxt();
        pulse_done(8'h07);
        for (int c = 0; c < 4; c++) begin
            nxt();
            chk($sformatf("t6_no_cpl%0d", c), push, 1'b0);
        end
        chk("t6_cnt_end", busy_cnt, 4'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
